// File: rtl/oled_spi_burst_ctrl.sv
// Purpose: write-only SPI master for an OLED panel: sends 0..MAXBYTES bytes MSB-first with a per-byte D/C line.
// Latency: per byte T_SETUP + 8*CLKDIV + T_HOLD + T_GAP cycles from accept to done; count 0 completes 1 cycle after accept.
// Backpressure: send_i is taken only while rdy_o=1 and ignored otherwise; the payload is latched on accept.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   send_i                  transaction request (sampled only while rdy_o=1)
//   numbytes_i              byte count; values above MAXBYTES are clamped to MAXBYTES
//   cmd_i                   payload, byte k in [8k+7:8k], byte 0 is sent first
//   dcsel_i                 data/command flag per byte, bit k for byte k
//   rdy_o, done_o           idle/ready, one-cycle completion pulse
//   sclk_o, sdo_o, cs_n_o, dc_o   SPI clock, data, chip select, data/command line
//
// Macro OLED_SPI_BURST_CS_EN: when defined, cs_n_o stays low across all bytes of a
// transaction (CLKDIV idle cycles between bytes); otherwise every byte is framed on its own.
module oled_spi_burst_ctrl #(
    parameter int MAXBYTES = 4,
    parameter int CLKDIV   = 200,
    parameter int T_SETUP  = 200,
    parameter int T_HOLD   = 200,
    parameter int T_GAP    = 400,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            send_i,
    input  logic [$clog2(MAXBYTES+1)-1:0]   numbytes_i,
    input  logic [8*MAXBYTES-1:0]           cmd_i,
    input  logic [MAXBYTES-1:0]             dcsel_i,
    output logic                            rdy_o,
    output logic                            done_o,
    output logic                            sclk_o,
    output logic                            sdo_o,
    output logic                            cs_n_o,
    output logic                            dc_o
);

`ifdef OLED_SPI_BURST_CS_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int NB_W = $clog2(MAXBYTES + 1);

    // Zero-length waits are treated as one cycle so the down-counters never underflow.
    localparam int TS_C = (T_SETUP < 1) ? 1 : T_SETUP;
    localparam int TH_C = (T_HOLD  < 1) ? 1 : T_HOLD;
    localparam int TG_C = (T_GAP   < 1) ? 1 : T_GAP;
    localparam int M_A  = (TS_C > TH_C) ? TS_C : TH_C;
    localparam int M_B  = (TG_C > CLKDIV) ? TG_C : CLKDIV;
    localparam int TMAX = (M_A > M_B) ? M_A : M_B;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int DW   = $clog2(CLKDIV);

    localparam logic [TW-1:0] TS_LD = TW'(TS_C - 1);
    localparam logic [TW-1:0] TH_LD = TW'(TH_C - 1);
    localparam logic [TW-1:0] TG_LD = TW'(TG_C - 1);
    localparam logic [TW-1:0] CD_LD = TW'(CLKDIV - 1);
    localparam logic [DW-1:0] HALF_END = DW'(CLKDIV / 2 - 1);
    localparam logic [DW-1:0] FULL_END = DW'(CLKDIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                  state_q;
    logic                    rdy_q, done_q, cs_n_q, sclk_q, sdo_q, dc_q;
    logic [TW-1:0]           tmr_q;
    logic [DW-1:0]           div_q;
    logic [2:0]              bit_q;
    logic [NB_W-1:0]         rem_q;     // bytes still to send, including the one in flight
    logic [8*MAXBYTES-1:0]   cmd_q;     // current byte always sits in [7:0]
    logic [MAXBYTES-1:0]     dcsel_q;   // current byte's flag always sits in bit 0
    logic [7:0]              sh_q;

    logic [NB_W-1:0]         nbytes_d;
    logic [MAXBYTES-1:0]     dcsel_d;

    always_comb begin
        nbytes_d = numbytes_i;
        if (numbytes_i > NB_W'(MAXBYTES)) begin
            nbytes_d = NB_W'(MAXBYTES);
        end
        dcsel_d = dcsel_q >> 1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= CPOL;
            sdo_q   <= 1'b0;
            dc_q    <= 1'b0;
            tmr_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            cmd_q   <= '0;
            dcsel_q <= '0;
            sh_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (send_i && rdy_q) begin
                        rdy_q   <= 1'b0;
                        cmd_q   <= cmd_i;
                        dcsel_q <= dcsel_i;
                        rem_q   <= nbytes_d;
                        tmr_q   <= TS_LD;
                        state_q <= SETUP;
                        // An empty request passes through SETUP with cs_n kept high.
                        if (nbytes_d != '0) begin
                            cs_n_q <= 1'b0;
                            dc_q   <= dcsel_i[0];
                        end
                    end
                end
                SETUP: begin
                    if (rem_q == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        rdy_q   <= 1'b1;
                    end else if (tmr_q == '0) begin
                        state_q <= SHIFT;
                        div_q   <= '0;
                        bit_q   <= '0;
                        // Mode CPHA=0 presents bit 7 half a period before the first edge.
                        if (!CPHA) begin
                            sdo_q <= cmd_q[7];
                            sh_q  <= {cmd_q[6:0], 1'b0};
                        end else begin
                            sh_q  <= cmd_q[7:0];
                        end
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                SHIFT: begin
                    div_q <= div_q + DW'(1);
                    if (div_q == HALF_END) begin
                        sclk_q <= ~CPOL;            // leading edge
                        if (CPHA) begin
                            sdo_q <= sh_q[7];
                            sh_q  <= {sh_q[6:0], 1'b0};
                        end
                    end
                    if (div_q == FULL_END) begin
                        div_q  <= '0;
                        sclk_q <= CPOL;             // trailing edge
                        if (bit_q == 3'd7) begin
                            rem_q <= rem_q - NB_W'(1);
                            if (BURST && (rem_q > NB_W'(1))) begin
                                // Next byte follows after CLKDIV idle cycles, cs_n held low.
                                cmd_q   <= cmd_q >> 8;
                                dcsel_q <= dcsel_d;
                                dc_q    <= dcsel_d[0];
                                tmr_q   <= CD_LD;
                                state_q <= SETUP;
                            end else begin
                                tmr_q   <= TH_LD;
                                state_q <= HOLD;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            if (!CPHA) begin
                                sdo_q <= sh_q[7];
                                sh_q  <= {sh_q[6:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tmr_q == '0) begin
                        cs_n_q  <= 1'b1;
                        sdo_q   <= 1'b0;
                        tmr_q   <= TG_LD;
                        state_q <= GAP;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                GAP: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - TW'(1);
                    end else if (rem_q != '0) begin
                        cmd_q   <= cmd_q >> 8;
                        dcsel_q <= dcsel_d;
                        dc_q    <= dcsel_d[0];
                        cs_n_q  <= 1'b0;
                        tmr_q   <= TS_LD;
                        state_q <= SETUP;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        rdy_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdy_o  = rdy_q;
    assign done_o = done_q;
    assign sclk_o = sclk_q;
    assign sdo_o  = sdo_q;
    assign cs_n_o = cs_n_q;
    assign dc_o   = dc_q;

endmodule

// File: tb/tb_oled_spi_burst_ctrl.sv
// Purpose: directed self-checking bench for oled_spi_burst_ctrl (mode 0 and mode 3 instances).
// Latency: expected cycle counts are derived from the timing parameters below.
// Backpressure: exercises send toggling while the block is busy.
module tb_oled_spi_burst_ctrl;

    localparam int MB = 4;
    localparam int CD = 4;
    localparam int TS = 2;
    localparam int TH = 2;
    localparam int TG = 3;
    localparam int T1 = TS + 8*CD + TH;     // cs_n low time of one separately framed byte

`ifdef OLED_SPI_BURST_CS_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       send0, rdy0, done0, sclk0, sdo0, cs0, dc0;
    logic [2:0] nb0;
    logic [31:0] cmd0;
    logic [3:0] dcs0;
    logic       send1, rdy1, done1, sclk1, sdo1, cs1, dc1;
    logic [2:0] nb1;
    logic [31:0] cmd1;
    logic [3:0] dcs1;

    oled_spi_burst_ctrl #(.MAXBYTES(MB), .CLKDIV(CD), .T_SETUP(TS), .T_HOLD(TH), .T_GAP(TG),
                          .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .send_i(send0), .numbytes_i(nb0), .cmd_i(cmd0),
        .dcsel_i(dcs0), .rdy_o(rdy0), .done_o(done0), .sclk_o(sclk0), .sdo_o(sdo0),
        .cs_n_o(cs0), .dc_o(dc0));

    oled_spi_burst_ctrl #(.MAXBYTES(MB), .CLKDIV(CD), .T_SETUP(TS), .T_HOLD(TH), .T_GAP(TG),
                          .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .send_i(send1), .numbytes_i(nb1), .cmd_i(cmd1),
        .dcsel_i(dcs1), .rdy_o(rdy1), .done_o(done1), .sclk_o(sclk1), .sdo_o(sdo1),
        .cs_n_o(cs1), .dc_o(dc1));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave models: both modes sample on the rising sclk edge.
    logic [7:0] rx0[$];
    logic       dcq0[$];
    logic [7:0] sh0 = '0;
    int         bitc0 = 0;
    always @(posedge sclk0) if (cs0 === 1'b0) begin
        sh0 = {sh0[6:0], sdo0};
        bitc0 = bitc0 + 1;
        if (bitc0 == 8) begin
            rx0.push_back(sh0);
            dcq0.push_back(dc0);
            bitc0 = 0;
        end
    end
    always @(posedge cs0) bitc0 = 0;

    logic [7:0] rx1[$];
    logic [7:0] sh1 = '0;
    int         bitc1 = 0;
    always @(posedge sclk1) if (cs1 === 1'b0) begin
        sh1 = {sh1[6:0], sdo1};
        bitc1 = bitc1 + 1;
        if (bitc1 == 8) begin
            rx1.push_back(sh1);
            bitc1 = 0;
        end
    end
    always @(posedge cs1) bitc1 = 0;

    // cs_n low-window lengths and minimum high gap between windows, in clk cycles.
    int win_q[$];
    int lowc = 0;
    int hic = 0;
    int gap_min = 1000;
    bit seen_win = 1'b0;
    int done_n0 = 0;
    always @(negedge clk) begin
        if (done0 === 1'b1) done_n0++;
        if (cs0 === 1'b0) begin
            if (lowc == 0 && seen_win && hic < gap_min) gap_min = hic;
            lowc++;
        end else if (lowc > 0) begin
            win_q.push_back(lowc);
            lowc = 0;
            hic = 1;
            seen_win = 1'b1;
        end else begin
            hic++;
        end
    end

    function automatic int exp_win(input int n);
        return BURST ? (TS + n*8*CD + (n-1)*CD + TH) : T1;
    endfunction
    function automatic int exp_cyc(input int n);
        return BURST ? (exp_win(n) + TG) : n*(T1 + TG);
    endfunction
    function automatic int exp_nwin(input int n);
        return BURST ? 1 : n;
    endfunction

    task automatic clr0();
        win_q.delete();
        rx0.delete();
        dcq0.delete();
        seen_win = 1'b0;
        gap_min = 1000;
    endtask

    task automatic wait_rdy0();
        int t = 0;
        while (rdy0 !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rdy_wait", rdy0, 1);
    endtask

    // Issues one request on dut0 and returns cycles from the accepting edge to done.
    task automatic run0(input logic [2:0] n, input logic [31:0] c, input logic [3:0] d,
                        output int cyc);
        wait_rdy0();
        send0 = 1'b1; nb0 = n; cmd0 = c; dcs0 = d;
        @(negedge clk);
        send0 = 1'b0;
        chk("rdy_drop", rdy0, 0);
        cyc = 0;
        while (done0 !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done0, 1);
        chk("rdy_with_done", rdy0, 1);
        @(negedge clk);
        chk("done_one_cycle", done0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        n_err++;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $fatal(1);
    end

    initial begin
        int cyc;
        int t;
        int dn;
        logic [7:0] exp_b[4];
        logic       exp_d[4];

        rst_n = 1'b0;
        send0 = 1'b0; nb0 = '0; cmd0 = '0; dcs0 = '0;
        send1 = 1'b0; nb1 = '0; cmd1 = '0; dcs1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy0, 0);
        chk("rst_cs_n", cs0, 1);
        chk("rst_sclk", sclk0, 0);
        chk("rst_sdo", sdo0, 0);
        chk("rst_dc", dc0, 0);
        chk("rst_done", done0, 0);
        chk("rst_sclk_cpol1", sclk1, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_first_edge", rdy0, 1);

        // Test 1: single byte 0xA5, mode 0.
        clr0();
        run0(3'd1, 32'h0000_00A5, 4'b0000, cyc);
        chk("t1_cycles", cyc, exp_cyc(1));
        chk("t1_nwin", win_q.size(), 1);
        chk("t1_cs_low", win_q[0], T1);
        chk("t1_nbytes", rx0.size(), 1);
        chk("t1_byte", rx0[0], 8'hA5);
        chk("t1_dc", dcq0[0], 0);

        // Test 2: three bytes, dc only on the last.
        clr0();
        run0(3'd3, 32'h0081_7FAE, 4'b0100, cyc);
        chk("t2_cycles", cyc, exp_cyc(3));
        chk("t2_nwin", win_q.size(), exp_nwin(3));
        chk("t2_win0", win_q[0], exp_win(3));
        chk("t2_gap", gap_min, BURST ? 1000 : TG);
        chk("t2_nbytes", rx0.size(), 3);
        chk("t2_b0", rx0[0], 8'hAE);
        chk("t2_b1", rx0[1], 8'h7F);
        chk("t2_b2", rx0[2], 8'h81);
        chk("t2_dc0", dcq0[0], 0);
        chk("t2_dc1", dcq0[1], 0);
        chk("t2_dc2", dcq0[2], 1);

        // Test 3: zero bytes, then a count above MAXBYTES.
        clr0();
        run0(3'd0, 32'hDEAD_BEEF, 4'hF, cyc);
        chk("t3_zero_cycles", cyc, 1);
        chk("t3_zero_nwin", win_q.size(), 0);
        chk("t3_zero_nbytes", rx0.size(), 0);
        clr0();
        run0(3'd7, 32'h4433_2211, 4'b1010, cyc);
        chk("t3_clamp_cycles", cyc, exp_cyc(4));
        chk("t3_clamp_nwin", win_q.size(), exp_nwin(4));
        chk("t3_clamp_nbytes", rx0.size(), 4);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_b%0d", i), rx0[i], exp_b[i]);
            chk($sformatf("t3_dc%0d", i), dcq0[i], exp_d[i]);
        end

        // Test 4: mode 3 on dut1.
        chk("t4_rdy", rdy1, 1);
        chk("t4_sclk_idle", sclk1, 1);
        send1 = 1'b1; nb1 = 3'd1; cmd1 = 32'h0000_003C; dcs1 = 4'b0001;
        @(negedge clk);
        send1 = 1'b0;
        t = 0;
        while (done1 !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("t4_done", done1, 1);
        chk("t4_cycles", t, exp_cyc(1));
        chk("t4_nbytes", rx1.size(), 1);
        chk("t4_byte", rx1[0], 8'h3C);
        chk("t4_sclk_end", sclk1, 1);

        // Test 5: reset in the middle of byte 1.
        clr0();
        wait_rdy0();
        dn = done_n0;
        send0 = 1'b1; nb0 = 3'd2; cmd0 = 32'h0000_5A96; dcs0 = 4'b0000;
        @(negedge clk);
        send0 = 1'b0;
        t = 0;
        while (!(rx0.size() == 1 && bitc0 == 4) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("t5_reached_bit4", bitc0, 4);
        rst_n = 1'b0;
        #1;
        chk("t5_cs_n", cs0, 1);
        chk("t5_sclk", sclk0, 0);
        chk("t5_rdy", rdy0, 0);
        repeat (3) @(negedge clk);
        chk("t5_no_done", done_n0, dn);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rdy_back", rdy0, 1);
        clr0();
        run0(3'd1, 32'h0000_0069, 4'b0000, cyc);
        chk("t5_after_cycles", cyc, exp_cyc(1));
        chk("t5_after_nbytes", rx0.size(), 1);
        chk("t5_after_byte", rx0[0], 8'h69);

        // Test 6: send toggling and payload changes while busy.
        clr0();
        wait_rdy0();
        dn = done_n0;
        send0 = 1'b1; nb0 = 3'd1; cmd0 = 32'h0000_00C3; dcs0 = 4'b0001;
        t = 0;
        forever begin
            @(negedge clk);
            if (done0 === 1'b1 || t >= 5000) begin
                send0 = 1'b0;
                break;
            end
            t++;
            send0 = ~send0;
            cmd0 = $urandom;
            nb0 = 3'd4;
            dcs0 = 4'($urandom_range(0, 15));
        end
        chk("t6_done", done0, 1);
        repeat (60) @(negedge clk);
        chk("t6_ndone", done_n0 - dn, 1);
        chk("t6_nwin", win_q.size(), 1);
        chk("t6_nbytes", rx0.size(), 1);
        chk("t6_byte", rx0[0], 8'hC3);
        chk("t6_dc", dcq0[0], 1);
        chk("t6_rdy", rdy0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
